manchester_tx_encoder: RTL
==========================

Name: manchester_tx_encoder

Overview:
- Sits directly downstream of the preamble-insertion stage and consumes its AXI-Stream byte output (2×0xAA, 0xD5, payload, tlast).
- Serializes each byte and Manchester-encodes it (IEEE 802.3 polarity) onto a single-bit line, together with a transmit-enable.
- Enforces an inter-frame gap after each frame.
- Aborts the frame cleanly if the upstream stalls mid-frame (underrun).

Parameters:
- DATA_WIDTH, 8: byte width; only 8 is supported.
- HALF_BIT_CYCLES, 4: aclk cycles per Manchester half-bit; legal range 1..255.
- IFG_BITS, 12: inter-frame gap length in bit times; legal range 1..255.
- LSB_FIRST, 1: 1 = bit 0 transmitted first, 0 = MSB first.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  byte to transmit.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- s_axis_tlast  in  1  last byte of frame.
- tx_out  out  1  Manchester line.
- tx_en  out  1  high while a frame is on the line.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  one-cycle pulse on frame abort.

Behaviour:
- Reset (async assert, sync release) forces: state=IDLE, tx_out=0, tx_en=0, busy=0, underrun=0, all counters 0, shift register 0. A reset mid-frame drops tx_en on the reset edge with no completion.
- Encoding: bit 1 = low half then high half; bit 0 = high half then low half. Each half-bit lasts exactly HALF_BIT_CYCLES cycles. A byte occupies 16·HALF_BIT_CYCLES cycles.
- tx_out, tx_en, busy and underrun are registered. s_axis_tready is combinational from state and counters, and never depends on s_axis_tvalid.
- States:
  - IDLE: tready=1. On handshake at edge T: latch byte and tlast, state→SHIFT. tx_en=1 and the first half-bit are on tx_out from cycle T+1.
  - SHIFT: half-cycle counter 0..HALF_BIT_CYCLES−1, half index 0..1, bit index 0..7.
    - tready=1 only in the final cycle of the second half of bit 7, and only if the latched tlast=0.
    - Handshake in that cycle: the new byte's first half-bit follows with no gap, so the line is continuous across bytes.
    - Latched tlast=1 at end of bit 7: state→GAP.
    - Latched tlast=0 and no tvalid in that cycle: underrun=1 for one cycle, state→GAP.
  - GAP: tx_en=0, tx_out=0, tready=0. Lasts IFG_BITS·2·HALF_BIT_CYCLES cycles, then state→IDLE.
- Counter widths are sized from the parameters. The gap counter must hold IFG_BITS·2·HALF_BIT_CYCLES without overflow.
- Bytes sent after tlast never enter mid-gap because tready=0 in GAP.
- tvalid dropping while tready=0 has no effect; only the sample in the tready=1 cycle matters.
- tlast on a single-byte frame is legal: one byte, then GAP.
- tx_out is held 0 whenever tx_en=0.

Test Plan:
- HALF_BIT_CYCLES=1, LSB_FIRST=1; send single byte 0xD5 with tlast.
  - tx_out from T+1 = 0,1,1,0,0,1,1,0,0,1,1,0,0,1,0,1.
  - tx_en high exactly 16 cycles, then 24 gap cycles with tx_en=0, then tready=1.
- HALF=4; frame AA,AA,D5,3C (tlast on 3C) held valid back-to-back.
  - tready pulses exactly once per 64 cycles.
  - tx_en is continuously high for 256 cycles with no gap between bytes.
  - Decoded line equals the four input bytes.
- HALF=2; 2-byte frame with tvalid deasserted during the final cycle of byte 1.
  - underrun pulses 1 cycle.
  - tx_en falls on the next cycle; GAP runs 48 cycles; the second byte is not consumed.
- LSB_FIRST=0, HALF=1; byte 0x80 with tlast.
  - tx_out = 0,1 followed by seven repetitions of 1,0.
- Assert aresetn low at byte 1, bit 3, while HALF=3.
  - All outputs 0 immediately, asynchronously; state is IDLE and tready=1 on the first cycle after release.
- Hold tvalid high with tlast during GAP.
  - tready stays 0 for the full IFG_BITS·2·HALF cycles; the byte is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/manchester_tx_encoder.sv
// Manchester line encoder (IEEE 802.3 polarity) fed by an AXI-Stream byte source.
// Serializes bytes back-to-back within a frame, enforces an inter-frame gap, aborts on underrun.
module manchester_tx_encoder #(
  parameter int DATA_WIDTH      = 8,
  parameter int HALF_BIT_CYCLES = 4,
  parameter int IFG_BITS        = 12,
  parameter int LSB_FIRST       = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  tx_out,
  output logic                  tx_en,
  output logic                  busy,
  output logic                  underrun
);

  localparam int GAP_CYCLES = IFG_BITS * 2 * HALF_BIT_CYCLES;
  localparam int HW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  last_r;
  logic [HW-1:0]         half_cnt_r;
  logic                  half_idx_r;
  logic [BW-1:0]         bit_idx_r;
  logic [GW-1:0]         gap_cnt_r;
  logic                  tx_out_r;
  logic                  tx_en_r;
  logic                  busy_r;
  logic                  underrun_r;

  logic                  half_end_s;
  logic                  byte_end_s;
  logic                  ready_s;
  logic                  accept_s;

  // Bit that goes on the line next, honouring the configured bit order.
  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] d);
    return (LSB_FIRST != 0) ? d[0] : d[DATA_WIDTH-1];
  endfunction

  // Drop the bit just sent so the next one sits in the lead position.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d);
    return (LSB_FIRST != 0) ? {1'b0, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], 1'b0};
  endfunction

  // Ready is open in IDLE and in the very last cycle of a non-final byte; never looks at tvalid.
  always_comb begin
    half_end_s = (half_cnt_r == HALF_LAST);
    byte_end_s = half_end_s && half_idx_r && (bit_idx_r == BIT_LAST);
    case (state_r)
      ST_IDLE:  ready_s = 1'b1;
      ST_SHIFT: ready_s = byte_end_s && !last_r;
      ST_GAP:   ready_s = 1'b0;
      default:  ready_s = 1'b0;
    endcase
    accept_s = ready_s && s_axis_tvalid;
  end

  // Frame sequencer: serializer, half-bit timing, gap timer and registered line outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= ST_IDLE;
      shift_r    <= {DATA_WIDTH{1'b0}};
      last_r     <= 1'b0;
      half_cnt_r <= {HW{1'b0}};
      half_idx_r <= 1'b0;
      bit_idx_r  <= {BW{1'b0}};
      gap_cnt_r  <= {GW{1'b0}};
      tx_out_r   <= 1'b0;
      tx_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_SHIFT;
            shift_r    <= s_axis_tdata;
            last_r     <= s_axis_tlast;
            half_cnt_r <= {HW{1'b0}};
            half_idx_r <= 1'b0;
            bit_idx_r  <= {BW{1'b0}};
            tx_out_r   <= ~lead_bit(s_axis_tdata);
            tx_en_r    <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!half_end_s) begin
            half_cnt_r <= half_cnt_r + HW'(1'b1);
          end else begin
            half_cnt_r <= {HW{1'b0}};
            if (!half_idx_r) begin
              // second half carries the true bit value
              half_idx_r <= 1'b1;
              tx_out_r   <= lead_bit(shift_r);
            end else if (bit_idx_r != BIT_LAST) begin
              half_idx_r <= 1'b0;
              bit_idx_r  <= bit_idx_r + BW'(1'b1);
              shift_r    <= advance(shift_r);
              tx_out_r   <= ~lead_bit(advance(shift_r));
            end else if (accept_s) begin
              // next byte continues the line with no idle half-bit
              half_idx_r <= 1'b0;
              bit_idx_r  <= {BW{1'b0}};
              shift_r    <= s_axis_tdata;
              last_r     <= s_axis_tlast;
              tx_out_r   <= ~lead_bit(s_axis_tdata);
            end else begin
              state_r    <= ST_GAP;
              half_idx_r <= 1'b0;
              bit_idx_r  <= {BW{1'b0}};
              shift_r    <= {DATA_WIDTH{1'b0}};
              gap_cnt_r  <= {GW{1'b0}};
              tx_out_r   <= 1'b0;
              tx_en_r    <= 1'b0;
              underrun_r <= !last_r;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= {GW{1'b0}};
            busy_r    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1'b1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          half_cnt_r <= {HW{1'b0}};
          half_idx_r <= 1'b0;
          bit_idx_r  <= {BW{1'b0}};
          gap_cnt_r  <= {GW{1'b0}};
          tx_out_r   <= 1'b0;
          tx_en_r    <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = ready_s;
  assign tx_out        = tx_out_r;
  assign tx_en         = tx_en_r;
  assign busy          = busy_r;
  assign underrun      = underrun_r;

endmodule
